// File: rtl/pdm_tx_pkg.sv
// rtl/pdm_tx_pkg.sv - shared encodings and helpers for the PCM-to-PDM transmitter
package pdm_tx_pkg;

    localparam int PCM_W = 16;

    typedef enum logic [1:0] {
        CTRL_NOP   = 2'b00,
        CTRL_START = 2'b01,
        CTRL_STOP  = 2'b10,
        CTRL_ABORT = 2'b11
    } ctrl_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Signed two's-complement to offset binary: midscale 0 maps to 0x8000.
    function automatic logic [PCM_W-1:0] to_offset_binary(input logic [PCM_W-1:0] x);
        return {~x[PCM_W-1], x[PCM_W-2:0]};
    endfunction

endpackage

// File: rtl/pdm_tx_if.sv
// rtl/pdm_tx_if.sv - host control, sample write and status bundle for pdm_tx
interface pdm_tx_if #(
    parameter int DEPTH = 16
);
    import pdm_tx_pkg::*;

    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [1:0]       ctrl;
    logic             wr_en;
    logic [PCM_W-1:0] wr_data;
    logic             clr_flags;
    logic             full;
    logic [LVL_W-1:0] level;
    logic             bsy;
    logic             underrun;
    logic             overflow;
    logic [15:0]      udf_count;

    modport master (
        output ctrl, wr_en, wr_data, clr_flags,
        input  full, level, bsy, underrun, overflow, udf_count
    );

    modport slave (
        input  ctrl, wr_en, wr_data, clr_flags,
        output full, level, bsy, underrun, overflow, udf_count
    );

endinterface

// File: rtl/pdm_tx_fifo.sv
// rtl/pdm_tx_fifo.sv - synchronous sample FIFO with flush; no write-to-read bypass
module pdm_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign pop_data = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // Storage has no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/pdm_tx.sv
// rtl/pdm_tx.sv - PCM-to-PDM playback transmitter with first-order sigma-delta modulator
// Optional saturating underrun counter enabled by defining PDM_TX_UDF_CNT_EN.
module pdm_tx
    import pdm_tx_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int CLK_DIV = 4,
    parameter int OSR     = 64
) (
    input  logic       clk,
    input  logic       rst,
    pdm_tx_if.slave    host,
    output logic       pdm_clk_out,
    output logic       pdm_out
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int SW = (OSR > 1) ? $clog2(OSR) : 1;

    state_e           state;
    state_e           state_nxt;
    logic [DW-1:0]    div;
    logic [SW-1:0]    sctr;
    logic [PCM_W-1:0] acc;
    logic [PCM_W-1:0] cur;
    logic [PCM_W-1:0] x;
    logic [PCM_W:0]   acc17;

    logic             active;
    logic             bit_tick;
    logic             load_pt;
    logic             abort;
    logic             start_clr;
    logic             bsy;
    logic             pop;
    logic             emit;
    logic             udf_evt;
    logic             drain_done;

    logic             fifo_full;
    logic             fifo_empty;
    logic [PCM_W-1:0] fifo_data;

    pdm_tx_fifo #(
        .DEPTH (DEPTH),
        .W     (PCM_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort),
        .push      (host.wr_en),
        .push_data (host.wr_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (host.level)
    );

    assign active      = (state != IDLE);
    assign bit_tick    = active && (div == DW'(CLK_DIV - 1));
    assign load_pt     = bit_tick && (sctr == '0);
    assign abort       = (host.ctrl == CTRL_ABORT);
    assign start_clr   = (state == IDLE) && (host.ctrl == CTRL_START);
    assign pdm_clk_out = active && (div >= DW'(CLK_DIV / 2));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (host.ctrl == CTRL_START) state_nxt = RUN;
                RUN:     if (host.ctrl == CTRL_STOP)  state_nxt = DRAIN;
                DRAIN:   if (load_pt && fifo_empty)   state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Drain ends on the load point that finds the FIFO empty: that period emits nothing.
    always_comb begin
        bsy        = (state != IDLE);
        pop        = 1'b0;
        emit       = 1'b0;
        udf_evt    = 1'b0;
        drain_done = 1'b0;
        if (!abort) begin
            case (state)
                RUN: begin
                    if (bit_tick) begin
                        emit = 1'b1;
                        if (load_pt) begin
                            if (fifo_empty) udf_evt = 1'b1;
                            else            pop     = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (bit_tick) begin
                        if (load_pt && fifo_empty) begin
                            drain_done = 1'b1;
                        end else begin
                            emit = 1'b1;
                            pop  = load_pt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // The sample loaded on a tick is modulated on that same tick.
    always_comb begin
        x = cur;
        if (load_pt) x = pop ? fifo_data : '0;
        acc17 = {1'b0, acc} + {1'b0, to_offset_binary(x)};
    end

    always_ff @(posedge clk) begin
        if (rst || abort || (state == IDLE) || drain_done) begin
            div     <= '0;
            sctr    <= '0;
            acc     <= '0;
            cur     <= '0;
            pdm_out <= 1'b0;
        end else begin
            div <= bit_tick ? '0 : div + 1'b1;
            if (emit) begin
                sctr    <= (sctr == SW'(OSR - 1)) ? '0 : sctr + 1'b1;
                acc     <= acc17[PCM_W-1:0];
                pdm_out <= acc17[PCM_W];
                if (load_pt) cur <= x;
            end
        end
    end

    // Sticky flags: a same-cycle set overrides any clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            host.underrun <= 1'b0;
            host.overflow <= 1'b0;
        end else begin
            if (host.clr_flags || start_clr) begin
                host.underrun <= 1'b0;
                host.overflow <= 1'b0;
            end
            if (udf_evt)                  host.underrun <= 1'b1;
            if (host.wr_en && fifo_full)  host.overflow <= 1'b1;
        end
    end

`ifdef PDM_TX_UDF_CNT_EN
    logic [15:0] udf_cnt;
    logic [15:0] udf_base;

    assign udf_base = (host.clr_flags || start_clr) ? 16'h0000 : udf_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            udf_cnt <= 16'h0000;
        end else if (udf_evt) begin
            udf_cnt <= (udf_base == 16'hFFFF) ? udf_base : udf_base + 16'h0001;
        end else begin
            udf_cnt <= udf_base;
        end
    end

    assign host.udf_count = udf_cnt;
`else
    assign host.udf_count = 16'h0000;
`endif

    assign host.full = fifo_full;
    assign host.bsy  = bsy;

endmodule
